// File: rtl/wb_sevenseg_if.sv
// rtl/wb_sevenseg_if.sv - Wishbone slave bus bundle for the seven-segment display controller
interface wb_sevenseg_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_sevenseg.sv
// rtl/wb_sevenseg.sv - Wishbone slave scanning a 4-digit multiplexed 7-segment display with PWM brightness
// Registers: DATA (hex), CTRL, RAW (segment patterns), SCAN (read-only scan position).
module wb_sevenseg #(
  parameter int clk_freq   = 50000000,
  parameter int refresh_hz = 1000
) (
  input  logic          clk,
  input  logic          reset,
  wb_sevenseg_if.slave  wb,
  output logic [6:0]    seg_n,
  output logic          dp_n,
  output logic [3:0]    an_n
);

  localparam int SUB_DIV = clk_freq / (refresh_hz * 64);
  localparam int PW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SUB_DIV - 1);

  if (SUB_DIV < 1) begin : g_bad_div
    $error("wb_sevenseg: clk_freq/(refresh_hz*64) must be at least 1");
  end

  logic [15:0]   data_q, data_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic [31:0]   raw_q, raw_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sub_q, sub_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          req;
  logic          wr_en;
  logic [31:0]   rd_data;
  logic          lit;
  logic [3:0]    nibble;
  logic [7:0]    raw_byte;
  logic          unused_ok;

  assign unused_ok = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0]};

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // A request is accepted only while ack is low, so a held strobe acks every other cycle.
  assign req   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr_en = req & wb.wb_we_i;

  always_comb begin
    rd_data = 32'h0;
    case (wb.wb_adr_i[3:2])
      2'd0:    rd_data = {16'h0, data_q};
      2'd1:    rd_data = {16'h0, ctrl_q};
      2'd2:    rd_data = raw_q;
      default: rd_data = {26'h0, sub_q, digit_q};
    endcase
  end

  always_comb begin
    ack_d  = req;
    dat_d  = (req & ~wb.wb_we_i) ? rd_data : 32'h0;
    data_d = data_q;
    ctrl_d = ctrl_q;
    raw_d  = raw_q;
    if (wr_en) begin
      case (wb.wb_adr_i[3:2])
        2'd0: begin
          if (wb.wb_sel_i[0]) data_d[7:0]  = wb.wb_dat_i[7:0];
          if (wb.wb_sel_i[1]) data_d[15:8] = wb.wb_dat_i[15:8];
        end
        2'd1: begin
          if (wb.wb_sel_i[0]) ctrl_d[7:0]  = wb.wb_dat_i[7:0];
          if (wb.wb_sel_i[1]) ctrl_d[15:8] = wb.wb_dat_i[15:8];
        end
        2'd2: begin
          for (int b = 0; b < 4; b++) begin
            if (wb.wb_sel_i[b]) raw_d[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Prescaler -> 16 subphases per digit -> 4 digits; the digit only moves on subphase wrap.
  always_comb begin
    presc_d = presc_q + 1'b1;
    sub_d   = sub_q;
    digit_d = digit_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      sub_d   = sub_q + 4'd1;
      if (sub_q == 4'hF) digit_d = digit_q + 2'd1;
    end
  end

  always_comb begin
    nibble   = data_q[{digit_q, 2'b00} +: 4];
    raw_byte = raw_q[{digit_q, 3'b000} +: 8];
    lit      = ctrl_q[0] & ctrl_q[8 + {2'b00, digit_q}] & (sub_q <= ctrl_q[15:12]);
    an_d     = 4'hF;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    if (lit) begin
      an_d = ~(4'b0001 << digit_q);
      if (ctrl_q[1]) begin
        seg_d = ~raw_byte[6:0];
        dp_d  = ~raw_byte[7];
      end else begin
        seg_d = ~hex_decode(nibble);
        dp_d  = ~ctrl_q[4 + {2'b00, digit_q}];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      raw_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      presc_q <= '0;
      sub_q   <= '0;
      digit_q <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      raw_q   <= raw_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      presc_q <= presc_d;
      sub_q   <= sub_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign dp_n        = dp_q;

endmodule
